// File: rtl/ram_sdp_be_banked.sv
// Banked simple-dual-port RAM with per-lane byte enables, read-during-write forwarding,
// optional output register, read-valid flag and sticky out-of-range detection.
module ram_sdp_be_banked #(
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDRESSABLE_SIZE = 8,
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned DEPTH            = 1024,
  parameter int unsigned MACRO_ADDR_WIDTH = 8,
  parameter bit          FORWARD          = 1'b1,
  parameter bit          OUT_REG          = 1'b0,
  parameter string       DATAFILE         = "",
  parameter bit          DO_INIT          = 1'b0,
  localparam int unsigned NUM_LANES       = DATA_WIDTH / ADDRESSABLE_SIZE
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic [NUM_LANES-1:0]  wren,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  q_valid,
  output logic                  oor_err,
  input  logic                  oor_clr
);

  localparam int unsigned BankWords = 2 ** MACRO_ADDR_WIDTH;
  localparam int unsigned NumBanks  = (DEPTH + BankWords - 1) / BankWords;
  localparam int unsigned BankW     = (NumBanks > 1) ? $clog2(NumBanks) : 1;
  localparam int unsigned MuxSize   = 2 ** BankW;
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  function automatic logic [BankW-1:0] bankOf(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH+BankW-1:0] s;
    s = {{BankW{1'b0}}, a} >> MACRO_ADDR_WIDTH;
    return s[BankW-1:0];
  endfunction

  function automatic logic [MACRO_ADDR_WIDTH-1:0] rowOf(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH+MACRO_ADDR_WIDTH-1:0] e;
    e = {{MACRO_ADDR_WIDTH{1'b0}}, a};
    return e[MACRO_ADDR_WIDTH-1:0];
  endfunction

  logic                        wrInRange, rdInRange, doWrite, doRead;
  logic [BankW-1:0]            wrBank, rdBank;
  logic [MACRO_ADDR_WIDTH-1:0] wrRow, rdRow;
  logic [DATA_WIDTH-1:0]       bankDout [MuxSize];
  logic [DATA_WIDTH-1:0]       bankWord, mergedWord, stage1Word;

  logic                  rdValidQ, rdOorQ, fwdMatchQ, oorErrQ;
  logic [DATA_WIDTH-1:0] fwdDataQ, qHoldQ;
  logic [NUM_LANES-1:0]  fwdWrenQ;
  logic                  rdOorEvent, wrOorEvent, oorErrD;

  assign wrInRange = {1'b0, wraddress} < DepthLim;
  assign rdInRange = {1'b0, rdaddress} < DepthLim;
  assign wrBank    = bankOf(wraddress);
  assign rdBank    = bankOf(rdaddress);
  assign wrRow     = rowOf(wraddress);
  assign rdRow     = rowOf(rdaddress);
  // A write sampled while reset is low is dropped.
  assign doWrite   = reset_n && wrInRange && (|wren);
  assign doRead    = reset_n && rden && rdInRange;

  for (genvar b = 0; b < NumBanks; b++) begin : gBank
    logic [DATA_WIDTH-1:0] mem [BankWords];
    logic [DATA_WIDTH-1:0] dout;
    logic                  bankWe, bankRe;

    assign bankWe = doWrite && ((NumBanks == 1) || (wrBank == BankW'(b)));
    assign bankRe = doRead && ((NumBanks == 1) || (rdBank == BankW'(b)));

    // Macro-style bank: registered read port, read-before-write on a shared row.
    always_ff @(posedge clock) begin
      if (bankRe) dout <= mem[rdRow];
      for (int l = 0; l < NUM_LANES; l++) begin
        if (bankWe && wren[l]) begin
          mem[wrRow][l*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE] <=
            data[l*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE];
        end
      end
    end

    assign bankDout[b] = dout;
  end

  for (genvar b = NumBanks; b < MuxSize; b++) begin : gPad
    assign bankDout[b] = '0;
  end

  if (NumBanks == 1) begin : gOneBank
    assign bankWord = bankDout[0];
  end else begin : gBankMux
    logic [BankW-1:0] rdBankQ;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        rdBankQ <= '0;
      end else if (rden) begin
        rdBankQ <= rdBank;
      end
    end
    assign bankWord = bankDout[rdBankQ];
  end

  always_comb begin
    mergedWord = bankWord;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (fwdMatchQ && fwdWrenQ[l]) begin
        mergedWord[l*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE] =
          fwdDataQ[l*ADDRESSABLE_SIZE +: ADDRESSABLE_SIZE];
      end
    end
    if (rdOorQ) mergedWord = '0;
  end

  // qHoldQ keeps the last delivered word so q holds while no read is in flight.
  assign stage1Word = rdValidQ ? mergedWord : qHoldQ;

  assign wrOorEvent = (|wren) && !wrInRange;
  assign rdOorEvent = OUT_REG ? (rdValidQ && rdOorQ) : (rden && !rdInRange);
  assign oorErrD    = (oorErrQ && !oor_clr) || wrOorEvent || rdOorEvent;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdValidQ  <= 1'b0;
      rdOorQ    <= 1'b0;
      fwdMatchQ <= 1'b0;
      fwdDataQ  <= '0;
      fwdWrenQ  <= '0;
      qHoldQ    <= '0;
      oorErrQ   <= 1'b0;
    end else begin
      rdValidQ <= rden;
      if (rden) begin
        rdOorQ    <= !rdInRange;
        fwdMatchQ <= FORWARD && rdInRange && (|wren) && (rdaddress == wraddress);
        fwdDataQ  <= data;
        fwdWrenQ  <= wren;
      end
      qHoldQ  <= stage1Word;
      oorErrQ <= oorErrD;
    end
  end

  assign oor_err = oorErrQ;

  if (OUT_REG) begin : gOutReg
    logic [DATA_WIDTH-1:0] qOutQ;
    logic                  qValidOutQ;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        qOutQ      <= '0;
        qValidOutQ <= 1'b0;
      end else begin
        qOutQ      <= stage1Word;
        qValidOutQ <= rdValidQ;
      end
    end
    assign q       = qOutQ;
    assign q_valid = qValidOutQ;
  end else begin : gNoOutReg
    assign q       = stage1Word;
    assign q_valid = rdValidQ;
  end

endmodule

// File: tb/tb_ram_sdp_be_banked.sv
// Directed bench: u0 is the default build (forwarding, latency 1, 1024 words),
// u1 is FORWARD=0, OUT_REG=1, DEPTH=600; both share the same stimulus.
module tb_ram_sdp_be_banked;

  logic        clock;
  logic        reset_n;
  logic [31:0] data;
  logic [9:0]  wraddress, rdaddress;
  logic [3:0]  wren;
  logic        rden, oor_clr;

  logic [31:0] q0, q1;
  logic        qv0, qv1, oor0, oor1;

  int checks = 0;
  int errors = 0;

  logic [31:0] vals [4] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_F0F0, 32'hCAFE_F00D};

  ram_sdp_be_banked u0 (
    .clock(clock), .reset_n(reset_n), .data(data), .wraddress(wraddress), .wren(wren),
    .rdaddress(rdaddress), .rden(rden), .q(q0), .q_valid(qv0), .oor_err(oor0),
    .oor_clr(oor_clr)
  );

  ram_sdp_be_banked #(
    .DEPTH(600), .FORWARD(1'b0), .OUT_REG(1'b1)
  ) u1 (
    .clock(clock), .reset_n(reset_n), .data(data), .wraddress(wraddress), .wren(wren),
    .rdaddress(rdaddress), .rden(rden), .q(q1), .q_valid(qv1), .oor_err(oor1),
    .oor_clr(oor_clr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] en);
    wraddress = a;
    data      = d;
    wren      = en;
    cyc();
    wren = 4'h0;
  endtask

  initial begin
    reset_n = 1'b0; data = '0; wraddress = '0; wren = '0;
    rdaddress = '0; rden = 1'b0; oor_clr = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_q0", q0, 32'h0);
    check("reset_qv0", {31'b0, qv0}, 32'h0);
    check("reset_oor0", {31'b0, oor0}, 32'h0);
    check("reset_qv1", {31'b0, qv1}, 32'h0);
    reset_n = 1'b1;
    cyc();

    // Full-word write then read, latency 1 (u0) and 2 (u1)
    wr(10'd5, 32'hDEAD_BEEF, 4'hF);
    rdaddress = 10'd5; rden = 1'b1;
    cyc();
    check("rd5_q0", q0, 32'hDEAD_BEEF);
    check("rd5_qv0", {31'b0, qv0}, 32'h1);
    check("rd5_qv1_early", {31'b0, qv1}, 32'h0);
    rden = 1'b0;
    cyc();
    check("rd5_qv0_drop", {31'b0, qv0}, 32'h0);
    check("rd5_q0_hold", q0, 32'hDEAD_BEEF);
    check("rd5_q1", q1, 32'hDEAD_BEEF);
    check("rd5_qv1", {31'b0, qv1}, 32'h1);

    // Same-cycle partial write and read of address 7
    wr(10'd7, 32'h1122_3344, 4'hF);
    wraddress = 10'd7; data = 32'hAABB_CCDD; wren = 4'b0101;
    rdaddress = 10'd7; rden = 1'b1;
    cyc();
    wren = 4'h0; rden = 1'b0;
    check("fwd_q0", q0, 32'h11BB_33DD);
    cyc();
    check("nofwd_q1", q1, 32'h1122_3344);
    rden = 1'b1;
    cyc();
    rden = 1'b0;
    check("after_fwd_q0", q0, 32'h11BB_33DD);
    cyc();
    check("after_wr_q1", q1, 32'h11BB_33DD);

    // Bank boundary, back-to-back reads
    wr(10'd255, 32'h0000_00AA, 4'hF);
    wr(10'd256, 32'h0000_00BB, 4'hF);
    rdaddress = 10'd255; rden = 1'b1;
    cyc();
    check("b0_q0", q0, 32'h0000_00AA);
    rdaddress = 10'd256;
    cyc();
    check("b1_q0", q0, 32'h0000_00BB);
    check("b0_q1", q1, 32'h0000_00AA);
    rden = 1'b0;
    cyc();
    check("b1_q1", q1, 32'h0000_00BB);

    // Out of range for u1 (DEPTH 600), in range for u0
    wr(10'd599, 32'h5A5A_5A5A, 4'hF);
    wr(10'd700, 32'h1234_5678, 4'hF);
    check("wr_oor1", {31'b0, oor1}, 32'h1);
    check("wr_oor0", {31'b0, oor0}, 32'h0);
    oor_clr = 1'b1;
    cyc();
    oor_clr = 1'b0;
    check("clr_oor1", {31'b0, oor1}, 32'h0);
    rdaddress = 10'd700; rden = 1'b1;
    cyc();
    rden = 1'b0;
    check("rd700_q0", q0, 32'h1234_5678);
    check("rd700_oor1_early", {31'b0, oor1}, 32'h0);
    cyc();
    check("rd700_q1", q1, 32'h0);
    check("rd700_qv1", {31'b0, qv1}, 32'h1);
    check("rd700_oor1", {31'b0, oor1}, 32'h1);
    oor_clr = 1'b1;
    cyc();
    check("clr_oor1_b", {31'b0, oor1}, 32'h0);
    wraddress = 10'd700; data = 32'hFFFF_FFFF; wren = 4'hF;
    cyc();
    wren = 4'h0;
    check("clr_vs_set_oor1", {31'b0, oor1}, 32'h1);
    cyc();
    oor_clr = 1'b0;
    check("clr_final_oor1", {31'b0, oor1}, 32'h0);
    rdaddress = 10'd599; rden = 1'b1;
    cyc();
    rden = 1'b0;
    cyc();
    check("noclamp_q1", q1, 32'h5A5A_5A5A);

    // Streaming reads 0..3
    for (int i = 0; i < 4; i++) wr(10'(i), vals[i], 4'hF);
    for (int i = 0; i < 4; i++) begin
      rdaddress = 10'(i); rden = 1'b1;
      cyc();
      check("stream_q0", q0, vals[i]);
      if (i == 0) check("stream_qv1_first", {31'b0, qv1}, 32'h0);
      else check("stream_q1", q1, vals[i-1]);
      if (i > 0) check("stream_qv1", {31'b0, qv1}, 32'h1);
    end
    rden = 1'b0;
    cyc();
    check("stream_q1_last", q1, vals[3]);

    // Asynchronous reset with reads in flight; write during reset is dropped
    rdaddress = 10'd0; rden = 1'b1;
    cyc();
    rdaddress = 10'd1;
    cyc();
    check("pre_rst_qv0", {31'b0, qv0}, 32'h1);
    check("pre_rst_q1", q1, vals[0]);
    #2 reset_n = 1'b0;
    #1;
    check("async_q0", q0, 32'h0);
    check("async_qv0", {31'b0, qv0}, 32'h0);
    check("async_q1", q1, 32'h0);
    check("async_qv1", {31'b0, qv1}, 32'h0);
    rden = 1'b0;
    wraddress = 10'd2; data = 32'hFFFF_FFFF; wren = 4'hF;
    cyc();
    wren = 4'h0;
    reset_n = 1'b1;
    cyc();
    rdaddress = 10'd2; rden = 1'b1;
    cyc();
    check("post_rst_a2_q0", q0, vals[2]);
    rdaddress = 10'd0;
    cyc();
    rden = 1'b0;
    check("post_rst_a0_q0", q0, vals[0]);
    check("post_rst_a2_q1", q1, vals[2]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
